// File: rtl/card_pkg.sv
// Shared definitions for the 7-segment card decoder.
// Contents:
//   HEX_*          active-low glyphs (bit 6 = g ... bit 0 = a)
//   card_t         4-bit card code, 1..13 legal, 0 = none, 15 = illegal
//   filt_state_t   debounce filter states
//   card_value()   baccarat points of a card (10/J/Q/K score 0)
package card_pkg;

  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_A     = 7'b0001000;
  localparam logic [6:0] HEX_2     = 7'b0100100;
  localparam logic [6:0] HEX_3     = 7'b0110000;
  localparam logic [6:0] HEX_4     = 7'b0011001;
  localparam logic [6:0] HEX_5     = 7'b0010010;
  localparam logic [6:0] HEX_6     = 7'b0000010;
  localparam logic [6:0] HEX_7     = 7'b1111000;
  localparam logic [6:0] HEX_8     = 7'b0000000;
  localparam logic [6:0] HEX_9     = 7'b0010000;
  localparam logic [6:0] HEX_0     = 7'b1000000;
  localparam logic [6:0] HEX_J     = 7'b1100001;
  localparam logic [6:0] HEX_Q     = 7'b0011000;
  localparam logic [6:0] HEX_K     = 7'b0001001;

  typedef enum logic [3:0] {
    CARD_NONE    = 4'd0,
    CARD_A       = 4'd1,
    CARD_2       = 4'd2,
    CARD_3       = 4'd3,
    CARD_4       = 4'd4,
    CARD_5       = 4'd5,
    CARD_6       = 4'd6,
    CARD_7       = 4'd7,
    CARD_8       = 4'd8,
    CARD_9       = 4'd9,
    CARD_10      = 4'd10,
    CARD_J       = 4'd11,
    CARD_Q       = 4'd12,
    CARD_K       = 4'd13,
    CARD_ILLEGAL = 4'd15
  } card_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } filt_state_t;

  function automatic logic [3:0] card_value(input card_t c);
    logic [3:0] v;
    v = 4'd0;
    if (c >= CARD_A && c <= CARD_9) v = 4'(c);
    return v;
  endfunction

endpackage

// File: rtl/seg7_to_card.sv
// Combinational 7-segment pattern to card decoder. Exact glyph match only.
// Ports:
//   seg_in  in   7  active-low segment pattern
//   card    out  4  decoded card (CARD_NONE for blank, CARD_ILLEGAL otherwise)
//   legal   out  1  pattern is one of the 13 card glyphs
module seg7_to_card
  import card_pkg::*;
(
  input  logic [6:0] seg_in,
  output card_t      card,
  output logic       legal
);

  always_comb begin
    card = CARD_ILLEGAL;
    unique case (seg_in)
      HEX_BLANK: card = CARD_NONE;
      HEX_A:     card = CARD_A;
      HEX_2:     card = CARD_2;
      HEX_3:     card = CARD_3;
      HEX_4:     card = CARD_4;
      HEX_5:     card = CARD_5;
      HEX_6:     card = CARD_6;
      HEX_7:     card = CARD_7;
      HEX_8:     card = CARD_8;
      HEX_9:     card = CARD_9;
      HEX_0:     card = CARD_10;
      HEX_J:     card = CARD_J;
      HEX_Q:     card = CARD_Q;
      HEX_K:     card = CARD_K;
      default:   card = CARD_ILLEGAL;
    endcase
  end

  assign legal = (card != CARD_NONE) && (card != CARD_ILLEGAL);

endmodule

// File: rtl/seg7_card_decoder.sv
// Debounces a sampled 7-segment pattern, decodes it to a card, delivers each
// card once over valid/ready and keeps a running baccarat hand score.
// Ports:
//   slow_clock   in   1  clock, rising edge
//   resetb       in   1  asynchronous active-low reset
//   seg_valid    in   1  seg_in is sampled this cycle
//   seg_in       in   7  active-low segment pattern
//   card_valid   out  1  output slot holds an undelivered card
//   card_ready   in   1  consumer takes the card this cycle
//   card_code    out  4  decoded card, 4'hF when illegal
//   card_err     out  1  delivered pattern was not a card glyph
//   clear_score  in   1  synchronous hand clear
//   score        out  4  hand score 0..9
//   card_cnt     out  2  cards scored this hand
//   overflow     out  1  sticky, legal card delivered with a full hand
//
// Filter states:
//   state | meaning
//   IDLE  | last pattern blank, nothing to emit
//   COUNT | non-blank pattern qualifying, counting identical samples
//   EMIT  | pattern qualified, waiting for the output slot to free up
//   DONE  | pattern delivered to the slot, held pattern is ignored
module seg7_card_decoder
  import card_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CARDS     = 3,
  localparam int RUN_W        = $clog2(STABLE_CYCLES + 1),
  localparam int CNT_W        = $clog2(MAX_CARDS + 1)
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             seg_valid,
  input  logic [6:0]       seg_in,
  output logic             card_valid,
  input  logic             card_ready,
  output logic [3:0]       card_code,
  output logic             card_err,
  input  logic             clear_score,
  output logic [3:0]       score,
  output logic [CNT_W-1:0] card_cnt,
  output logic             overflow
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CARDS);

  filt_state_t      state_q, state_d;
  logic [6:0]       last_pat_q, last_pat_d;
  logic [RUN_W-1:0] run_q, run_d;

  logic             card_valid_q, card_valid_d;
  card_t            card_code_q, card_code_d;
  logic             card_err_q, card_err_d;

  logic [3:0]       score_q, score_d;
  logic [CNT_W-1:0] card_cnt_q, card_cnt_d;
  logic             overflow_q, overflow_d;

  card_t            dec_card;
  logic             dec_legal;
  logic             slot_free;
  logic             handshake;
  logic             load;
  logic [4:0]       sum;

  // Decode the pattern the filter will hold after this edge; on every load
  // path that is exactly the pattern being emitted.
  seg7_to_card u_dec (
    .seg_in (last_pat_d),
    .card   (dec_card),
    .legal  (dec_legal)
  );

  assign handshake = card_valid_q && card_ready;
  assign slot_free = !card_valid_q || card_ready;

  always_comb begin
    state_d    = state_q;
    last_pat_d = last_pat_q;
    run_d      = run_q;
    load       = 1'b0;

    if (seg_valid) begin
      if (seg_in == last_pat_q) begin
        if (run_q != RUN_MAX) run_d = run_q + 1'b1;
      end else begin
        // Any change abandons whatever was qualifying or stalled.
        last_pat_d = seg_in;
        run_d      = RUN_W'(1);
        state_d    = (seg_in == HEX_BLANK) ? IDLE : COUNT;
      end
    end

    // A stalled EMIT retries every cycle, sampled or not.
    if ((state_d == COUNT && run_d == RUN_MAX) || state_d == EMIT) begin
      if (slot_free) begin
        load    = 1'b1;
        state_d = DONE;
      end else begin
        state_d = EMIT;
      end
    end
  end

  always_comb begin
    card_valid_d = card_valid_q && !card_ready;
    card_code_d  = card_code_q;
    card_err_d   = card_err_q;
    if (load) begin
      card_valid_d = 1'b1;
      card_code_d  = dec_card;
      card_err_d   = !dec_legal;
    end
  end

  assign sum = {1'b0, score_q} + {1'b0, card_value(card_code_q)};

  always_comb begin
    score_d    = score_q;
    card_cnt_d = card_cnt_q;
    overflow_d = overflow_q;
    if (clear_score) begin
      score_d    = 4'd0;
      card_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (handshake && !card_err_q) begin
      if (card_cnt_q < CNT_MAX) begin
        score_d    = 4'((sum >= 5'd10) ? (sum - 5'd10) : sum);
        card_cnt_d = card_cnt_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      last_pat_q   <= HEX_BLANK;
      run_q        <= '0;
      card_valid_q <= 1'b0;
      card_code_q  <= CARD_NONE;
      card_err_q   <= 1'b0;
      score_q      <= 4'd0;
      card_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_pat_q   <= last_pat_d;
      run_q        <= run_d;
      card_valid_q <= card_valid_d;
      card_code_q  <= card_code_d;
      card_err_q   <= card_err_d;
      score_q      <= score_d;
      card_cnt_q   <= card_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign card_valid = card_valid_q;
  assign card_code  = card_code_q;
  assign card_err   = card_err_q;
  assign score      = score_q;
  assign card_cnt   = card_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg7_card_decoder.sv
module tb_seg7_card_decoder;
  import card_pkg::*;

  logic       slow_clock;
  logic       resetb;
  logic       seg_valid;
  logic [6:0] seg_in;
  logic       card_valid;
  logic       card_ready;
  logic [3:0] card_code;
  logic       card_err;
  logic       clear_score;
  logic [3:0] score;
  logic [1:0] card_cnt;
  logic       overflow;

  logic [6:0] gold_pat;
  card_t      gold_card;
  logic       gold_legal;

  typedef struct {
    logic [3:0] code;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [6:0] PAT_ILL = 7'b1010101;

  seg7_card_decoder #(.STABLE_CYCLES(4), .MAX_CARDS(3)) dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .seg_valid   (seg_valid),
    .seg_in      (seg_in),
    .card_valid  (card_valid),
    .card_ready  (card_ready),
    .card_code   (card_code),
    .card_err    (card_err),
    .clear_score (clear_score),
    .score       (score),
    .card_cnt    (card_cnt),
    .overflow    (overflow)
  );

  seg7_to_card u_gold (
    .seg_in (gold_pat),
    .card   (gold_card),
    .legal  (gold_legal)
  );

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] code, input logic err);
    exp_t e;
    e.code = code;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      seg_valid = 1'b1;
      seg_in    = p;
      tick();
    end
    seg_valid = 1'b0;
  endtask

  task automatic check_hand(input string tag, input int s, input int c, input int o);
    check({tag, "_score"}, score, s);
    check({tag, "_card_cnt"}, card_cnt, c);
    check({tag, "_overflow"}, overflow, o);
  endtask

  // Monitor: every delivered card is popped from the scoreboard and compared.
  always @(negedge slow_clock) begin
    if (resetb && card_valid && card_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_card: got code %0d err %0d, expected none", card_code, card_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_card_code", card_code, e.code);
        check("sb_card_err", card_err, e.err);
      end
    end
  end

  logic [6:0] tbl_pat  [16] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                                7'b0011000, 7'b0001001, 7'b1010101, 7'b0111111};
  int         tbl_code [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 15, 15};

  initial begin
    resetb      = 1'b0;
    seg_valid   = 1'b0;
    seg_in      = HEX_BLANK;
    card_ready  = 1'b1;
    clear_score = 1'b0;
    gold_pat    = HEX_BLANK;

    // Glyph table of the shared decoder
    for (int i = 0; i < 16; i++) begin
      gold_pat = tbl_pat[i];
      #1;
      check("glyph_code", gold_card, tbl_code[i]);
      check("glyph_legal", gold_legal, (tbl_code[i] >= 1 && tbl_code[i] <= 13) ? 1 : 0);
    end

    // Reset state
    repeat (2) @(posedge slow_clock);
    #3;
    check("rst_card_valid", card_valid, 0);
    check("rst_card_code", card_code, 0);
    check("rst_card_err", card_err, 0);
    check_hand("rst", 0, 0, 0);
    resetb = 1'b1;
    tick();

    // Cards 4, 6, 7 without stall
    push(4'd4, 1'b0);
    drive(HEX_4, 3);
    check("c4_not_yet", card_valid, 0);
    drive(HEX_4, 1);
    check("c4_valid", card_valid, 1);
    check("c4_code", card_code, 4);
    drive(HEX_BLANK, 2);
    check_hand("c4", 4, 1, 0);
    push(4'd6, 1'b0);
    drive(HEX_6, 4);
    drive(HEX_BLANK, 1);
    check_hand("c6", 0, 2, 0);
    push(4'd7, 1'b0);
    drive(HEX_7, 4);
    drive(HEX_BLANK, 1);
    check_hand("c7", 7, 3, 0);
    check("c7_valid_drop", card_valid, 0);

    clear_score = 1'b1;
    tick();
    clear_score = 1'b0;
    check_hand("clr1", 0, 0, 0);

    // Glitch rejection
    push(4'd2, 1'b0);
    drive(HEX_2, 3);
    drive(HEX_3, 1);
    check("glitch_none_a", card_valid, 0);
    drive(HEX_2, 3);
    check("glitch_none_b", card_valid, 0);
    drive(HEX_2, 1);
    check("glitch_valid", card_valid, 1);
    check("glitch_code", card_code, 2);
    drive(HEX_BLANK, 1);
    check_hand("glitch", 2, 1, 0);

    clear_score = 1'b1;
    tick();
    clear_score = 1'b0;

    // Backpressure: K held, Q queued behind it
    card_ready = 1'b0;
    push(4'd13, 1'b0);
    drive(HEX_K, 4);
    drive(HEX_K, 10);
    check("bp_k_valid", card_valid, 1);
    check("bp_k_code", card_code, 13);
    push(4'd12, 1'b0);
    drive(HEX_Q, 4);
    check("bp_stall_code", card_code, 13);
    card_ready = 1'b1;
    tick();
    card_ready = 1'b0;
    check("bp_q_valid", card_valid, 1);
    check("bp_q_code", card_code, 12);
    check_hand("bp_k", 0, 1, 0);
    card_ready = 1'b1;
    drive(HEX_Q, 6);
    check("bp_no_reemit", card_valid, 0);
    check_hand("bp_q", 0, 2, 0);
    drive(HEX_BLANK, 1);

    // Illegal pattern
    push(4'hF, 1'b1);
    drive(PAT_ILL, 4);
    check("ill_code", card_code, 15);
    check("ill_err", card_err, 1);
    drive(HEX_BLANK, 1);
    check_hand("ill", 0, 2, 0);

    // Overflow then clear racing a handshake
    push(4'd1, 1'b0);
    drive(HEX_A, 4);
    drive(HEX_BLANK, 1);
    check_hand("third", 1, 3, 0);
    push(4'd9, 1'b0);
    drive(HEX_9, 4);
    drive(HEX_BLANK, 1);
    check_hand("ovf", 1, 3, 1);
    card_ready = 1'b0;
    push(4'd1, 1'b0);
    drive(HEX_A, 4);
    check("clr_a_valid", card_valid, 1);
    card_ready  = 1'b1;
    clear_score = 1'b1;
    tick();
    clear_score = 1'b0;
    check_hand("clr2", 0, 0, 0);
    check("clr2_consumed", card_valid, 0);
    drive(HEX_BLANK, 1);

    // Async reset mid-count with a pending card
    push(4'd3, 1'b0);
    drive(HEX_3, 4);
    drive(HEX_BLANK, 1);
    check_hand("pre_rst", 3, 1, 0);
    card_ready = 1'b0;
    drive(HEX_5, 4);
    check("pre_rst_valid", card_valid, 1);
    drive(HEX_8, 2);
    seg_valid = 1'b1;
    seg_in    = HEX_8;
    #2;
    resetb = 1'b0;
    #1;
    check("arst_card_valid", card_valid, 0);
    check("arst_card_code", card_code, 0);
    check("arst_card_err", card_err, 0);
    check_hand("arst", 0, 0, 0);
    @(posedge slow_clock);
    #3;
    resetb     = 1'b1;
    card_ready = 1'b1;
    push(4'd8, 1'b0);
    drive(HEX_8, 3);
    check("post_rst_not_yet", card_valid, 0);
    drive(HEX_8, 1);
    check("post_rst_valid", card_valid, 1);
    check("post_rst_code", card_code, 8);
    drive(HEX_BLANK, 2);
    check_hand("post_rst", 8, 1, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_card_decoder.md
Name: seg7_card_decoder

Overview:
- Inverse of the card-to-7-segment encoder: samples a 7-segment pattern (active-low segments, bit 6 = g … bit 0 = a), debounces it, decodes it back to a 4-bit card code, and delivers each card once over a valid/ready handshake.
- Keeps a running baccarat hand score: sum of card values mod 10.
- Used as a scoreboard/monitor beside the HEX outputs, and as a loop-back checker on the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical valid samples needed before a pattern is accepted (≥1).
- MAX_CARDS, 3: number of cards scored per hand before overflow.

Ports:
- slow_clock  in  1  single clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- seg_valid  in  1  seg_in is sampled this cycle.
- seg_in  in  7  7-segment pattern, active-low.
- card_valid  out  1  card_code/card_err hold an undelivered card.
- card_ready  in  1  consumer accepts the card this cycle.
- card_code  out  4  decoded card: 1=A, 2..9, 10 (pattern "0"), 11=J, 12=Q, 13=K; 4'hF if illegal.
- card_err  out  1  delivered pattern was not a legal card glyph.
- clear_score  in  1  synchronous hand clear.
- score  out  4  hand score, 0..9.
- card_cnt  out  2  cards scored this hand, 0..MAX_CARDS.
- overflow  out  1  sticky; a legal card was delivered while card_cnt==MAX_CARDS.

Behaviour:
- Reset (resetb=0, async): card_valid=0, card_code=0, card_err=0, score=0, card_cnt=0, overflow=0, filter in IDLE, run counter=0.
- Decode table (exact match only): 1111111 blank; 0001000 A; 0100100 2; 0110000 3; 0011001 4; 0010010 5; 0000010 6; 1111000 7; 0000000 8; 0010000 9; 1000000 10; 1100001 J; 0011000 Q; 0001001 K. Any other value is illegal.
- Filter tracks last_pat and run count (width $clog2(STABLE_CYCLES+1), saturating).
  - seg_valid=0: filter state and run count hold.
  - seg_valid=1, seg_in==last_pat: run count increments.
  - seg_valid=1, seg_in!=last_pat: last_pat<=seg_in, run count<=1, state returns to COUNT (or IDLE if seg_in is blank).
- Filter states:
  - IDLE: last pattern blank; nothing is emitted. A non-blank sample moves to COUNT.
  - COUNT: when run count reaches STABLE_CYCLES → EMIT.
  - EMIT: loads the output register if the slot is empty, or is being emitted this cycle with card_ready=1; then → DONE. Otherwise waits in EMIT (stall). A pattern change while in EMIT abandons that card.
  - DONE: a held pattern is never re-emitted. A change to a new pattern re-arms via COUNT; a change to blank goes to IDLE. A-A-A with no blank between emits one card.
- Latency: output register loads on the edge where the STABLE_CYCLES-th identical sample is taken. card_valid is high the following cycle.
- Output handshake:
  - card_valid stays high and card_code/card_err stay stable until a cycle with card_valid&&card_ready. card_valid drops after that edge unless a new card loads the same edge.
  - Single-entry slot, no queue.
- Score update on handshake of a legal card:
  - If card_cnt<MAX_CARDS: score<=(score+val)%10, where val=code for 1..9 and 0 for 10..13; card_cnt++.
  - Else: overflow<=1; score and card_cnt unchanged.
  - Illegal cards do not touch score, card_cnt or overflow.
- Arithmetic: 5-bit intermediate sum (max 9+9=18), subtract 10 if ≥10.
- clear_score=1: score<=0, card_cnt<=0, overflow<=0. It wins over a same-cycle handshake, so that card is consumed but unscored. It does not affect the filter or the output slot.
- Reset mid-stall or mid-count drops everything. After reset, the pattern currently present must re-qualify from count 0.

Decomposition:
- Package card_pkg:
  - HEX_* 7-bit glyph constants.
  - typedef enum logic [3:0] card_t {CARD_NONE=0, CARD_A=1, … CARD_K=13, CARD_ILLEGAL=15}.
  - typedef enum {IDLE, COUNT, EMIT, DONE} filt_state_t.
  - function card_value(card_t) returning baccarat points 0..9.
- Sub-module seg7_to_card: purely combinational, pattern → card_t plus legal flag. Instantiated once. Shared with the bench, which uses it as the golden decoder.

Test Plan:
- Cards 4, 6, 7, no stall: seg_in=0011001 for 4 valid cycles, blank 2 cycles, then 0000010 ×4, blank, 1111000 ×4, card_ready=1. Expected: three pulses with codes 4, 6, 7, card_err=0, card_cnt=3, score 4→0→7.
- Glitch rejection: 0100100 ×3, then 0110000 ×1, then 0100100 ×4. Expected: exactly one card, code 2, emitted on the 4th sample of the final run.
- Backpressure: K stable with card_ready=0 for 10 cycles. Expected: card_valid=1, code 13 held; held K not re-emitted. Then Q stable arrives while K is pending. Expected: Q loads on the edge K is accepted (card_ready=1); score stays 0 (K and Q are worth 0) while card_cnt increments.
- Illegal pattern: 1010101 ×4. Expected: card_code=4'hF, card_err=1; score and card_cnt unchanged after handshake.
- Overflow and clear: 4th legal card (9) after MAX_CARDS=3 scored. Expected: overflow=1, score unchanged. Then clear_score asserted in the same cycle as the handshake of an A. Expected: score=0, card_cnt=0, overflow=0.
- Async reset: resetb low mid-COUNT with card_valid=1. Expected: all outputs 0 immediately. After release, the still-present 8 pattern needs 4 fresh samples to emit code 8.
